// File: rtl/jd_byte_streamer.sv
// jd_byte_streamer: buffers byte-write pulses in a small FIFO and plays each
// byte out on the JD header. Every byte gets a setup window, a strobe pulse
// and a hold window of fixed length. Lives entirely in the clk_5mhz domain.
`timescale 1ns/1ps

module jd_byte_streamer #(
    parameter int FIFO_DEPTH    = 8,
    parameter int SETUP_CYCLES  = 2,
    parameter int STROBE_CYCLES = 4,
    parameter int HOLD_CYCLES   = 2
) (
    input  logic                          clk_5mhz,
    input  logic                          rst_ni,
    input  logic                          wr_i,
    input  logic [7:0]                    wr_data_i,
    input  logic                          clr_i,
    output logic [7:0]                    jd_data_o,
    output logic                          jd_stb_o,
    output logic                          busy_o,
    output logic [$clog2(FIFO_DEPTH):0]   level_o,
    output logic                          overflow_o,
    output logic [15:0]                   drop_cnt_o
);

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int LVL_W   = PTR_W + 1;
    localparam int MAX_CYC = (SETUP_CYCLES > STROBE_CYCLES)
                           ? ((SETUP_CYCLES > HOLD_CYCLES) ? SETUP_CYCLES : HOLD_CYCLES)
                           : ((STROBE_CYCLES > HOLD_CYCLES) ? STROBE_CYCLES : HOLD_CYCLES);
    localparam int TCNT_W  = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [TCNT_W-1:0] SETUP_LD  = TCNT_W'(SETUP_CYCLES - 1);
    localparam logic [TCNT_W-1:0] STROBE_LD = TCNT_W'(STROBE_CYCLES - 1);
    localparam logic [TCNT_W-1:0] HOLD_LD   = TCNT_W'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD
    } state_e;

    // FIFO storage and bookkeeping
    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [LVL_W-1:0] level_q;

    // Play-out sequencer
    state_e           state_q;
    state_e           state_d;
    logic [TCNT_W-1:0] tcnt_q;
    logic [TCNT_W-1:0] tcnt_d;
    logic             stb_q;
    logic             stb_d;
    logic [7:0]       data_q;

    // Error tracking
    logic             overflow_q;
    logic [15:0]      drop_cnt_q;

    logic fifo_nempty;
    logic pop;
    logic push;
    logic drop;

    assign fifo_nempty = (level_q != '0);

    // A full FIFO still takes a write when the head leaves in the same cycle.
    assign push = wr_i && ((level_q < LVL_W'(FIFO_DEPTH)) || pop);
    assign drop = wr_i && !push;

    // Write side of the byte store.
    // NOTE: the storage array has no reset; level_q and the pointers alone
    // decide which entries are valid, so clearing it would only cost logic.
    always_ff @(posedge clk_5mhz) begin
        if (push) begin
            mem[wr_ptr_q] <= wr_data_i;
        end
    end

    // Pointers and occupancy counter; pointers wrap naturally at FIFO_DEPTH.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the values from before this edge.
    always_ff @(posedge clk_5mhz or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (push && !pop) begin
                level_q <= level_q + LVL_W'(1);
            end else if (pop && !push) begin
                level_q <= level_q - LVL_W'(1);
            end
        end
    end

    // Sticky overflow flag and saturating drop counter; a drop in the same
    // cycle as a clear wins over the clear.
    always_ff @(posedge clk_5mhz or negedge rst_ni) begin
        if (!rst_ni) begin
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else if (clr_i) begin
            overflow_q <= drop;
            drop_cnt_q <= drop ? 16'd1 : 16'd0;
        end else if (drop) begin
            overflow_q <= 1'b1;
            if (drop_cnt_q != 16'hFFFF) begin
                drop_cnt_q <= drop_cnt_q + 16'd1;
            end
        end
    end

    // Sequencer state, window timer, strobe flop and the byte on the pins.
    always_ff @(posedge clk_5mhz or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            tcnt_q  <= '0;
            stb_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            tcnt_q  <= tcnt_d;
            stb_q   <= stb_d;
            if (pop) begin
                data_q <= mem[rd_ptr_q];
            end
        end
    end

    // Next-state logic: each window counts down to zero before moving on;
    // HOLD chains straight into the next SETUP when a byte is waiting.
    // NOTE: every signal driven here gets a default first so no latch is
    // inferred on paths that leave it untouched.
    always_comb begin
        state_d = state_q;
        tcnt_d  = tcnt_q;
        pop     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (fifo_nempty) begin
                    pop     = 1'b1;
                    tcnt_d  = SETUP_LD;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (tcnt_q == '0) begin
                    tcnt_d  = STROBE_LD;
                    state_d = STROBE;
                end else begin
                    tcnt_d = tcnt_q - TCNT_W'(1);
                end
            end
            STROBE: begin
                if (tcnt_q == '0) begin
                    tcnt_d  = HOLD_LD;
                    state_d = HOLD;
                end else begin
                    tcnt_d = tcnt_q - TCNT_W'(1);
                end
            end
            HOLD: begin
                if (tcnt_q == '0) begin
                    if (fifo_nempty) begin
                        pop     = 1'b1;
                        tcnt_d  = SETUP_LD;
                        state_d = SETUP;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    tcnt_d = tcnt_q - TCNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs: the strobe is precomputed from the next state so the pin
    // is driven straight from a flop and cannot glitch.
    always_comb begin
        stb_d  = (state_d == STROBE);
        busy_o = (state_q != IDLE) || fifo_nempty;
    end

    assign jd_data_o  = data_q;
    assign jd_stb_o   = stb_q;
    assign level_o    = level_q;
    assign overflow_o = overflow_q;
    assign drop_cnt_o = drop_cnt_q;

endmodule

// File: tb/tb_jd_byte_streamer.sv
// Self-checking bench for jd_byte_streamer: a per-cycle table for a single
// byte, hand-written corner sequences, and a randomized run against a
// queue-based reference model of the byte frames.
`timescale 1ns/1ps

module tb_jd_byte_streamer;

    localparam int FIFO_DEPTH    = 8;
    localparam int SETUP_CYCLES  = 2;
    localparam int STROBE_CYCLES = 4;
    localparam int HOLD_CYCLES   = 2;
    localparam int FRAME         = SETUP_CYCLES + STROBE_CYCLES + HOLD_CYCLES;
    localparam int LW            = $clog2(FIFO_DEPTH) + 1;

    logic          clk_5mhz = 1'b0;
    logic          rst_ni   = 1'b0;
    logic          wr_i     = 1'b0;
    logic [7:0]    wr_data_i = '0;
    logic          clr_i    = 1'b0;
    logic [7:0]    jd_data_o;
    logic          jd_stb_o;
    logic          busy_o;
    logic [LW-1:0] level_o;
    logic          overflow_o;
    logic [15:0]   drop_cnt_o;

    jd_byte_streamer #(
        .FIFO_DEPTH   (FIFO_DEPTH),
        .SETUP_CYCLES (SETUP_CYCLES),
        .STROBE_CYCLES(STROBE_CYCLES),
        .HOLD_CYCLES  (HOLD_CYCLES)
    ) dut (
        .clk_5mhz  (clk_5mhz),
        .rst_ni    (rst_ni),
        .wr_i      (wr_i),
        .wr_data_i (wr_data_i),
        .clr_i     (clr_i),
        .jd_data_o (jd_data_o),
        .jd_stb_o  (jd_stb_o),
        .busy_o    (busy_o),
        .level_o   (level_o),
        .overflow_o(overflow_o),
        .drop_cnt_o(drop_cnt_o)
    );

    // 5 MHz clock
    always #100 clk_5mhz = ~clk_5mhz;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // Reference model: a byte queue plus "cycles since the last pop".
    logic [7:0] m_q[$];
    bit         m_active;
    int         m_t;
    logic [7:0] m_data;
    bit         m_ovf;
    int         m_drop;

    // Strobe rising edges seen on the pins
    int         rise_cyc[$];
    logic [7:0] rise_data[$];
    logic       prev_stb = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_active = 1'b0;
        m_t      = 0;
        m_data   = '0;
        m_ovf    = 1'b0;
        m_drop   = 0;
    endtask

    // One clock edge of the model, using the inputs presented before it.
    task automatic model_step(input bit wr, input logic [7:0] data, input bit clr);
        bit pop;
        bit accept;
        bit drop;
        if (m_active) begin
            m_t++;
            if (m_t == FRAME) m_active = 1'b0;
        end
        pop    = !m_active && (m_q.size() != 0);
        accept = wr && ((m_q.size() < FIFO_DEPTH) || pop);
        drop   = wr && !accept;
        if (pop) begin
            m_data   = m_q.pop_front();
            m_active = 1'b1;
            m_t      = 0;
        end
        if (accept) m_q.push_back(data);
        if (clr) begin
            m_ovf  = drop;
            m_drop = drop ? 1 : 0;
        end else if (drop) begin
            m_ovf = 1'b1;
            if (m_drop != 65535) m_drop++;
        end
    endtask

    task automatic compare_model();
        bit exp_stb;
        exp_stb = m_active && (m_t >= SETUP_CYCLES) && (m_t < SETUP_CYCLES + STROBE_CYCLES);
        check("jd_data", 32'(jd_data_o), 32'(m_data));
        check("jd_stb", 32'(jd_stb_o), 32'(exp_stb));
        check("busy", 32'(busy_o), 32'(m_active || (m_q.size() != 0)));
        check("level", 32'(level_o), 32'(m_q.size()));
        check("overflow", 32'(overflow_o), 32'(m_ovf));
        check("drop_cnt", 32'(drop_cnt_o), 32'(m_drop));
    endtask

    // Drive inputs, advance one clock, then compare on the falling edge.
    task automatic run_cycle(input bit wr, input logic [7:0] data, input bit clr);
        wr_i      = wr;
        wr_data_i = data;
        clr_i     = clr;
        model_step(wr, data, clr);
        @(posedge clk_5mhz);
        @(negedge clk_5mhz);
        cyc++;
        if (jd_stb_o && !prev_stb) begin
            rise_cyc.push_back(cyc);
            rise_data.push_back(jd_data_o);
        end
        prev_stb = jd_stb_o;
        compare_model();
    endtask

    typedef struct packed {
        logic          wr;
        logic [7:0]    data;
        logic [7:0]    exp_data;
        logic          exp_stb;
        logic          exp_busy;
        logic [LW-1:0] exp_level;
    } vec_t;

    vec_t vecs[11];

    initial begin
        // Single byte A5 written at E0; row i shows outputs after edge Ei.
        vecs[0]  = '{1'b1, 8'hA5, 8'h00, 1'b0, 1'b1, LW'(1)};
        vecs[1]  = '{1'b0, 8'h00, 8'hA5, 1'b0, 1'b1, LW'(0)};
        vecs[2]  = '{1'b0, 8'h00, 8'hA5, 1'b0, 1'b1, LW'(0)};
        vecs[3]  = '{1'b0, 8'h00, 8'hA5, 1'b1, 1'b1, LW'(0)};
        vecs[4]  = '{1'b0, 8'h00, 8'hA5, 1'b1, 1'b1, LW'(0)};
        vecs[5]  = '{1'b0, 8'h00, 8'hA5, 1'b1, 1'b1, LW'(0)};
        vecs[6]  = '{1'b0, 8'h00, 8'hA5, 1'b1, 1'b1, LW'(0)};
        vecs[7]  = '{1'b0, 8'h00, 8'hA5, 1'b0, 1'b1, LW'(0)};
        vecs[8]  = '{1'b0, 8'h00, 8'hA5, 1'b0, 1'b1, LW'(0)};
        vecs[9]  = '{1'b0, 8'h00, 8'hA5, 1'b0, 1'b0, LW'(0)};
        vecs[10] = '{1'b0, 8'h00, 8'hA5, 1'b0, 1'b0, LW'(0)};

        model_reset();

        // Reset state
        repeat (3) @(negedge clk_5mhz);
        check("rst_jd_data", 32'(jd_data_o), 32'h0);
        check("rst_jd_stb", 32'(jd_stb_o), 32'h0);
        check("rst_busy", 32'(busy_o), 32'h0);
        check("rst_level", 32'(level_o), 32'h0);
        check("rst_overflow", 32'(overflow_o), 32'h0);
        check("rst_drop_cnt", 32'(drop_cnt_o), 32'h0);
        rst_ni = 1'b1;

        // Single byte, cycle by cycle
        for (int i = 0; i < 11; i++) begin
            run_cycle(vecs[i].wr, vecs[i].data, 1'b0);
            check($sformatf("tbl%0d_data", i), 32'(jd_data_o), 32'(vecs[i].exp_data));
            check($sformatf("tbl%0d_stb", i), 32'(jd_stb_o), 32'(vecs[i].exp_stb));
            check($sformatf("tbl%0d_busy", i), 32'(busy_o), 32'(vecs[i].exp_busy));
            check($sformatf("tbl%0d_level", i), 32'(level_o), 32'(vecs[i].exp_level));
        end

        // Burst of three bytes: strobes exactly one frame apart, in order
        rise_cyc.delete();
        rise_data.delete();
        for (int i = 1; i <= 3; i++) run_cycle(1'b1, 8'(i), 1'b0);
        for (int i = 0; i < 30; i++) run_cycle(1'b0, 8'h00, 1'b0);
        check("burst_strobes", 32'(rise_cyc.size()), 32'd3);
        if (rise_cyc.size() == 3) begin
            check("burst_gap1", 32'(rise_cyc[1] - rise_cyc[0]), 32'(FRAME));
            check("burst_gap2", 32'(rise_cyc[2] - rise_cyc[1]), 32'(FRAME));
            for (int i = 0; i < 3; i++)
                check($sformatf("burst_byte%0d", i), 32'(rise_data[i]), 32'(i + 1));
        end
        check("burst_overflow", 32'(overflow_o), 32'h0);

        // Eleven back-to-back writes from idle. Write 9 lands on a pop with
        // the FIFO full and is kept; write 10 is dropped.
        rise_cyc.delete();
        rise_data.delete();
        for (int i = 0; i <= 10; i++) begin
            run_cycle(1'b1, 8'(i), 1'b0);
            if (i == 8) check("full_level", 32'(level_o), 32'(FIFO_DEPTH));
            if (i == 9) begin
                check("fullpop_level", 32'(level_o), 32'(FIFO_DEPTH));
                check("fullpop_drop_cnt", 32'(drop_cnt_o), 32'h0);
                check("fullpop_overflow", 32'(overflow_o), 32'h0);
            end
        end
        check("ovf_overflow", 32'(overflow_o), 32'h1);
        check("ovf_drop_cnt", 32'(drop_cnt_o), 32'h1);

        // Clear alone, then clear in the same cycle as a drop
        run_cycle(1'b0, 8'h00, 1'b1);
        check("clr_overflow", 32'(overflow_o), 32'h0);
        check("clr_drop_cnt", 32'(drop_cnt_o), 32'h0);
        run_cycle(1'b1, 8'hEE, 1'b1);
        check("clrdrop_overflow", 32'(overflow_o), 32'h1);
        check("clrdrop_drop_cnt", 32'(drop_cnt_o), 32'h1);

        for (int i = 0; i < 90; i++) run_cycle(1'b0, 8'h00, 1'b0);
        check("ovf_bytes_out", 32'(rise_cyc.size()), 32'd10);
        for (int i = 0; i < 10 && i < rise_data.size(); i++)
            check($sformatf("ovf_byte%0d", i), 32'(rise_data[i]), 32'(i));

        // Reset while strobing with three bytes queued
        for (int i = 0; i < 4; i++) run_cycle(1'b1, 8'hC0 + 8'(i), 1'b0);
        for (int i = 0; i < 20 && !jd_stb_o; i++) run_cycle(1'b0, 8'h00, 1'b0);
        check("prerst_stb_seen", 32'(jd_stb_o), 32'h1);
        check("prerst_level", 32'(level_o), 32'd3);
        #20;
        rst_ni = 1'b0;
        wr_i   = 1'b0;
        clr_i  = 1'b0;
        #1;
        check("midrst_jd_stb", 32'(jd_stb_o), 32'h0);
        check("midrst_jd_data", 32'(jd_data_o), 32'h0);
        check("midrst_level", 32'(level_o), 32'h0);
        check("midrst_busy", 32'(busy_o), 32'h0);
        model_reset();
        repeat (2) @(negedge clk_5mhz);
        rst_ni   = 1'b1;
        prev_stb = 1'b0;
        rise_cyc.delete();
        rise_data.delete();
        for (int i = 0; i < 20; i++) run_cycle(1'b0, 8'h00, 1'b0);
        check("postrst_no_strobe", 32'(rise_cyc.size()), 32'h0);

        // Randomized traffic with varying write density and occasional clears
        for (int blk = 0; blk < 15; blk++) begin
            int pct;
            case (blk % 3)
                0:       pct = 10;
                1:       pct = 30;
                default: pct = 90;
            endcase
            for (int i = 0; i < 200; i++) begin
                run_cycle($urandom_range(99) < pct, 8'($urandom), $urandom_range(49) == 0);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
